axi_sram_slave: RTL and testbench

AXI4 slave wrapping the unified single-port SRAM that holds program and data for the 5-stage RV32I core. It sits between the AXI interconnect in `top_axi` and the storage array, and serves instruction fetch, load and store bursts. The storage sub-module is instanced as `mem0` with word array `mem`, so the simulation top reaches it as `TOP.mem0.mem0.mem`. That path is used for the `$readmemh` preload and for the golden-data compare.

---
 rtl/CPU_profile.sv | 9 +
 rtl/axi_pkg.sv | 72 +++++++
 rtl/sram_sp.sv | 39 +++
 rtl/axi_sram_slave.sv | 202 ++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/CPU_profile.sv
// CPU_profile: core-wide build profile shared by the RV32I pipeline and its
// memory-side blocks.
// Exports:
//   XLEN - native integer/data width of the core (RV32I -> 32)
package CPU_profile;

  localparam int XLEN = 32;

endpackage

// File: rtl/axi_pkg.sv
// axi_pkg: AXI4 channel payload types and encodings used by the SRAM slave
// and its testbench.
// Exports:
//   axi_aw_t / axi_ar_t - address channel {id, addr, len, size, burst}
//   axi_w_t             - write data {data, strb, last}
//   axi_b_t             - write response {id, resp}
//   axi_r_t             - read data {id, data, resp, last}
//   OKAY/SLVERR/DECERR, FIXED/INCR/WRAP, SIZE_WORD constants
//   slave_state_t       - transaction FSM states
//   worst_resp()        - picks the more severe of two responses
package axi_pkg;
  import CPU_profile::*;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = XLEN;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;

  // Only full 32-bit beats are served.
  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } axi_aw_t;

  typedef axi_aw_t axi_ar_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
    logic                  last;
  } axi_w_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
  } axi_b_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } axi_r_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_RESP,
    RD_FETCH,
    RD_DATA
  } slave_state_t;

  // The encodings are ordered by severity (DECERR > SLVERR > OKAY), so the
  // numerically larger code is the worse one.
  function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_sp.sv
// sram_sp: single-port SRAM with per-byte write enables and a registered
// (synchronous) read port. Contents are never reset so a preload survives
// reset.
// Ports:
//   clk   - clock
//   we    - write enable, bytes selected by be
//   be    - byte enables for the write
//   re    - read enable; rdata updates on the next clock edge
//   addr  - word index
//   wdata - write data
//   rdata - read data, holds until the next read
module sram_sp #(
  parameter int WORDS  = 16384,
  parameter int DATA_W = 32,
  localparam int IDX_W = $clog2(WORDS),
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic              re,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [WORDS];

  // Byte-masked write and registered read share the single address port.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 slave in front of the unified program/data SRAM of
// the RV32I core. Serves one burst at a time (FIXED or INCR, 32-bit beats).
// Ports:
//   ACLK, ARESETn          - clock, asynchronous active-low reset
//   AW/AWVALID/AWREADY     - write address channel
//   W/WVALID/WREADY        - write data channel
//   B/BVALID/BREADY        - write response (worst beat response)
//   AR/ARVALID/ARREADY     - read address channel
//   R/RVALID/RREADY        - read data, one beat every two cycles
module axi_sram_slave
  import CPU_profile::*, axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = XLEN,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_WORDS  = 16384
) (
  input  logic    ACLK,
  input  logic    ARESETn,
  input  axi_aw_t AW,
  input  logic    AWVALID,
  output logic    AWREADY,
  input  axi_w_t  W,
  input  logic    WVALID,
  output logic    WREADY,
  output axi_b_t  B,
  output logic    BVALID,
  input  logic    BREADY,
  input  axi_ar_t AR,
  input  logic    ARVALID,
  output logic    ARREADY,
  output axi_r_t  R,
  output logic    RVALID,
  input  logic    RREADY
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  slave_state_t state_q, state_d;

  logic                  rr_wr_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic [1:0]            burst_q;
  logic                  bad_q;
  logic [1:0]            bresp_q;
  logic [1:0]            rresp_q;

  logic                  grant_wr;
  logic                  aw_hs, ar_hs, w_hs, r_hs;
  logic                  beat_last;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  beat_dec;
  logic [1:0]            beat_resp;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [1:0]            last_resp;

  logic                  mem_we, mem_re;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // A lone valid channel always wins; on a tie the round-robin bit decides.
  assign grant_wr  = AWVALID && (!ARVALID || rr_wr_q);

  assign aw_hs     = AWREADY && AWVALID;
  assign ar_hs     = ARREADY && ARVALID;
  assign w_hs      = WREADY && WVALID;
  assign r_hs      = RVALID && RREADY;

  assign beat_last = (cnt_q == len_q);
  assign word_idx  = addr_q >> 2;
  assign beat_dec  = (word_idx >= ADDR_WIDTH'(MEM_WORDS));
  assign beat_resp = worst_resp(bad_q ? SLVERR : OKAY, beat_dec ? DECERR : OKAY);
  assign addr_next = (burst_q == FIXED) ? addr_q : addr_q + ADDR_WIDTH'(4);

  // A W.last that disagrees with the beat count poisons the whole burst.
  assign last_resp = (W.last != beat_last) ? SLVERR : OKAY;

  // Errored beats never touch the array.
  assign mem_we = w_hs && (beat_resp == OKAY);
  assign mem_re = (state_q == RD_FETCH) && (beat_resp == OKAY);

  sram_sp #(
    .WORDS (MEM_WORDS),
    .DATA_W(DATA_WIDTH)
  ) mem0 (
    .clk  (ACLK),
    .we   (mem_we),
    .be   (W.strb),
    .re   (mem_re),
    .addr (addr_q[IDX_W+1:2]),
    .wdata(W.data),
    .rdata(mem_rdata)
  );

  // State register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: bursts terminate on the latched len, never on W.last.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (aw_hs)      state_d = WR_DATA;
        else if (ar_hs) state_d = RD_FETCH;
      end
      WR_DATA:  if (w_hs && beat_last) state_d = WR_RESP;
      WR_RESP:  if (BREADY) state_d = IDLE;
      RD_FETCH: state_d = RD_DATA;
      RD_DATA:  if (r_hs) state_d = beat_last ? IDLE : RD_FETCH;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs decode purely from state so reset clears them asynchronously;
  // response payloads are forced to zero whenever their VALID is low.
  always_comb begin
    AWREADY = 1'b0;
    ARREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    RVALID  = 1'b0;
    B       = '0;
    R       = '0;
    case (state_q)
      IDLE: begin
        AWREADY = AWVALID && grant_wr;
        ARREADY = ARVALID && !grant_wr;
      end
      WR_DATA: WREADY = 1'b1;
      WR_RESP: begin
        BVALID = 1'b1;
        B.id   = id_q;
        B.resp = bresp_q;
      end
      RD_DATA: begin
        RVALID = 1'b1;
        R.id   = id_q;
        R.data = (rresp_q == OKAY) ? mem_rdata : '0;
        R.resp = rresp_q;
        R.last = beat_last;
      end
      default: ;
    endcase
  end

  // Burst bookkeeping: latch the request, step address/count per beat,
  // accumulate the write response and capture the per-beat read response
  // alongside the SRAM fetch.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rr_wr_q <= 1'b1;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      burst_q <= FIXED;
      bad_q   <= 1'b0;
      bresp_q <= OKAY;
      rresp_q <= OKAY;
    end else begin
      if (aw_hs) begin
        rr_wr_q <= 1'b0;
        id_q    <= AW.id;
        addr_q  <= {AW.addr[ADDR_WIDTH-1:2], 2'b00};
        len_q   <= AW.len;
        burst_q <= AW.burst;
        cnt_q   <= '0;
        bad_q   <= (AW.burst == WRAP) || (AW.size != SIZE_WORD);
        bresp_q <= OKAY;
      end else if (ar_hs) begin
        rr_wr_q <= 1'b1;
        id_q    <= AR.id;
        addr_q  <= {AR.addr[ADDR_WIDTH-1:2], 2'b00};
        len_q   <= AR.len;
        burst_q <= AR.burst;
        cnt_q   <= '0;
        bad_q   <= (AR.burst == WRAP) || (AR.size != SIZE_WORD);
      end

      if (w_hs) begin
        bresp_q <= worst_resp(bresp_q, worst_resp(beat_resp, last_resp));
        if (!beat_last) begin
          addr_q <= addr_next;
          cnt_q  <= cnt_q + 8'd1;
        end
      end

      if (state_q == RD_FETCH) rresp_q <= beat_resp;

      if (r_hs && !beat_last) begin
        addr_q <= addr_next;
        cnt_q  <= cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed self-checking bench for axi_sram_slave.
// Inputs change #1 after the rising edge, outputs are sampled on the falling
// edge. Memory contents are set and inspected only through the AXI ports.
module tb_axi_sram_slave;
  import axi_pkg::*;

  logic    ACLK = 1'b0;
  logic    ARESETn;
  axi_aw_t AW;
  logic    AWVALID, AWREADY;
  axi_w_t  W;
  logic    WVALID, WREADY;
  axi_b_t  B;
  logic    BVALID, BREADY;
  axi_ar_t AR;
  logic    ARVALID, ARREADY;
  axi_r_t  R;
  logic    RVALID, RREADY;

  int total = 0;
  int bad   = 0;

  logic [31:0] wvec [8];
  logic [3:0]  svec [8];
  logic [31:0] expd [8];
  logic [1:0]  expr [8];

  always #5 ACLK = ~ACLK;

  axi_sram_slave mem0 (
    .ACLK   (ACLK),
    .ARESETn(ARESETn),
    .AW     (AW),
    .AWVALID(AWVALID),
    .AWREADY(AWREADY),
    .W      (W),
    .WVALID (WVALID),
    .WREADY (WREADY),
    .B      (B),
    .BVALID (BVALID),
    .BREADY (BREADY),
    .AR     (AR),
    .ARVALID(ARVALID),
    .ARREADY(ARREADY),
    .R      (R),
    .RVALID (RVALID),
    .RREADY (RREADY)
  );

  // Single point of comparison: count it, report it if it differs.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic sigOf(input int which);
    case (which)
      0:       return AWREADY;
      1:       return ARREADY;
      3:       return BVALID;
      default: return RVALID;
    endcase
  endfunction

  // Wait (bounded) for a handshake signal, returning on the falling edge
  // where it is seen high.
  task automatic waitSig(input string tag, input int which);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (sigOf(which)) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_seen"}, ok, 1);
  endtask

  task automatic issueAw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    @(posedge ACLK); #1;
    AW = '{id: id, addr: addr, len: len, size: SIZE_WORD, burst: burst};
    AWVALID = 1'b1;
    waitSig("awready", 0);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
  endtask

  task automatic issueAr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    @(posedge ACLK); #1;
    AR = '{id: id, addr: addr, len: len, size: SIZE_WORD, burst: burst};
    ARVALID = 1'b1;
    waitSig("arready", 1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
  endtask

  // Drives wvec/svec as a burst right after the AW handshake, then checks
  // that exactly one B arrives the cycle after the last beat.
  task automatic applyStimulus(input string tag, input int len, input logic [3:0] exp_id,
                               input logic [1:0] exp_resp);
    for (int b = 0; b <= len; b++) begin
      W.data = wvec[b];
      W.strb = svec[b];
      W.last = (b == len);
      WVALID = 1'b1;
      @(negedge ACLK);
      checkOutput({tag, "_wready"}, WREADY, 1);
      @(posedge ACLK); #1;
    end
    WVALID = 1'b0;
    @(negedge ACLK);
    checkOutput({tag, "_bvalid"}, BVALID, 1);
    checkOutput({tag, "_bid"}, B.id, exp_id);
    checkOutput({tag, "_bresp"}, B.resp, exp_resp);
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    @(negedge ACLK);
    checkOutput({tag, "_bdone"}, BVALID, 0);
  endtask

  // Collects len+1 read beats against expd/expr, checking the T+2 latency
  // and optionally holding RREADY low for 5 cycles on one beat.
  task automatic readBeats(input string tag, input int len, input logic [3:0] exp_id,
                           input int stall_beat);
    @(negedge ACLK);
    checkOutput({tag, "_lat1"}, RVALID, 0);
    for (int b = 0; b <= len; b++) begin
      if (b == 0) begin
        @(negedge ACLK);
        checkOutput({tag, "_lat2"}, RVALID, 1);
      end else begin
        waitSig({tag, "_rvalid"}, 4);
      end
      checkOutput({tag, "_data"}, R.data, expd[b]);
      checkOutput({tag, "_resp"}, R.resp, expr[b]);
      checkOutput({tag, "_last"}, R.last, (b == len));
      checkOutput({tag, "_id"}, R.id, exp_id);
      if (b == stall_beat) begin
        repeat (5) begin
          @(negedge ACLK);
          checkOutput({tag, "_hold_valid"}, RVALID, 1);
          checkOutput({tag, "_hold_data"}, R.data, expd[b]);
        end
      end
      RREADY = 1'b1;
      @(posedge ACLK); #1;
      RREADY = 1'b0;
    end
  endtask

  initial begin
    ARESETn = 1'b0;
    AW = '0; AR = '0; W = '0;
    AWVALID = 1'b0; ARVALID = 1'b0; WVALID = 1'b0;
    BREADY = 1'b0; RREADY = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wvec[i] = '0; svec[i] = 4'hF; expd[i] = '0; expr[i] = OKAY;
    end

    // Reset state.
    repeat (3) @(negedge ACLK);
    checkOutput("rst_awready", AWREADY, 0);
    checkOutput("rst_arready", ARREADY, 0);
    checkOutput("rst_wready", WREADY, 0);
    checkOutput("rst_bvalid", BVALID, 0);
    checkOutput("rst_rvalid", RVALID, 0);
    checkOutput("rst_b", B, 0);
    checkOutput("rst_r", R, 0);
    ARESETn = 1'b1;

    // Simultaneous request straight after reset: write wins.
    @(posedge ACLK); #1;
    AW = '{id: 4'd1, addr: 32'h10, len: 8'd0, size: SIZE_WORD, burst: INCR};
    AR = '{id: 4'd2, addr: 32'h40, len: 8'd0, size: SIZE_WORD, burst: INCR};
    AWVALID = 1'b1; ARVALID = 1'b1;
    @(negedge ACLK);
    checkOutput("arb1_awready", AWREADY, 1);
    checkOutput("arb1_arready", ARREADY, 0);
    @(posedge ACLK); #1;
    AWVALID = 1'b0; ARVALID = 1'b0;
    wvec[0] = 32'hDEADBEEF; svec[0] = 4'hF;
    applyStimulus("w_single", 0, 4'd1, OKAY);

    // Next simultaneous request: read wins; single-beat read of mem[4].
    @(posedge ACLK); #1;
    AW = '{id: 4'd9, addr: 32'h200, len: 8'd0, size: SIZE_WORD, burst: INCR};
    AR = '{id: 4'd3, addr: 32'h10, len: 8'd0, size: SIZE_WORD, burst: INCR};
    AWVALID = 1'b1; ARVALID = 1'b1;
    @(negedge ACLK);
    checkOutput("arb2_arready", ARREADY, 1);
    checkOutput("arb2_awready", AWREADY, 0);
    @(posedge ACLK); #1;
    AWVALID = 1'b0; ARVALID = 1'b0;
    expd[0] = 32'hDEADBEEF; expr[0] = OKAY;
    readBeats("r_single", 0, 4'd3, -1);

    // 4-beat INCR write at 0x100, then read it back with a stall on beat 1.
    issueAw(4'd5, 32'h100, 8'd3, INCR);
    for (int i = 0; i < 4; i++) begin
      wvec[i] = 32'(i + 1); svec[i] = 4'hF; expd[i] = 32'(i + 1); expr[i] = OKAY;
    end
    applyStimulus("w_burst", 3, 4'd5, OKAY);
    issueAr(4'd6, 32'h100, 8'd3, INCR);
    readBeats("r_stall", 3, 4'd6, 1);

    // Byte strobe: only byte 1 of mem[8] is replaced.
    issueAw(4'd7, 32'h20, 8'd0, INCR);
    wvec[0] = 32'h11223344; svec[0] = 4'hF;
    applyStimulus("w_full", 0, 4'd7, OKAY);
    issueAw(4'd7, 32'h20, 8'd0, INCR);
    wvec[0] = 32'hAABBCCDD; svec[0] = 4'b0010;
    applyStimulus("w_strb", 0, 4'd7, OKAY);
    issueAr(4'd8, 32'h20, 8'd0, INCR);
    expd[0] = 32'h1122CC44; expr[0] = OKAY;
    readBeats("r_strb", 0, 4'd8, -1);

    // Read just past the end of the array: every beat DECERR with zero data.
    issueAr(4'd2, 32'h0001_0000, 8'd1, INCR);
    expd[0] = '0; expd[1] = '0; expr[0] = DECERR; expr[1] = DECERR;
    readBeats("r_decerr", 1, 4'd2, -1);

    // WRAP write is consumed but leaves memory untouched.
    issueAw(4'd4, 32'h30, 8'd1, INCR);
    wvec[0] = 32'h55667788; wvec[1] = 32'h0BADF00D; svec[0] = 4'hF; svec[1] = 4'hF;
    applyStimulus("w_pre_wrap", 1, 4'd4, OKAY);
    issueAw(4'd4, 32'h30, 8'd1, WRAP);
    wvec[0] = 32'hFFFFFFFF; wvec[1] = 32'hFFFFFFFF;
    applyStimulus("w_wrap", 1, 4'd4, SLVERR);
    issueAr(4'd4, 32'h30, 8'd1, INCR);
    expd[0] = 32'h55667788; expd[1] = 32'h0BADF00D; expr[0] = OKAY; expr[1] = OKAY;
    readBeats("r_after_wrap", 1, 4'd4, -1);

    // Reset in the middle of a read burst.
    issueAr(4'd1, 32'h100, 8'd3, INCR);
    waitSig("rst_mid_rvalid", 4);
    #1 ARESETn = 1'b0;
    #1;
    checkOutput("rst_mid_rvalid", RVALID, 0);
    checkOutput("rst_mid_r", R, 0);
    @(negedge ACLK);
    checkOutput("rst_mid_arready", ARREADY, 0);
    ARESETn = 1'b1;
    issueAr(4'd3, 32'h10, 8'd0, INCR);
    expd[0] = 32'hDEADBEEF; expr[0] = OKAY;
    readBeats("r_post_rst", 0, 4'd3, -1);
    issueAr(4'd3, 32'h104, 8'd0, INCR);
    expd[0] = 32'h2;
    readBeats("r_post_rst2", 0, 4'd3, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
